izh_step_sched: RTL and testbench
=================================

Name: izh_step_sched

Overview:
- Time-multiplexes one shared Izhikevich derivative datapath (dv/dw evaluator, fixed latency) across NUM_NEURONS neurons held in internal state registers.
- On each `start` pulse it sweeps all neurons once: it issues operands, collects derivatives, integrates v/w, applies spike reset, and reports spikes.
- It sits between the network timestep controller and the combinational/pipelined dv/dw arithmetic.

Parameters:
- N, 24, total fixed-point width (signed two's complement)
- Q, 8, fractional bits
- NUM_NEURONS, 4, neurons served per sweep (>=1)
- DP_LAT, 2, datapath result latency in cycles (>=0)
- IDX_W, $clog2(NUM_NEURONS) (min 1), neuron index width

Ports:
- clk, in, 1, clock
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, one-cycle pulse; begin a sweep (ignored while busy)
- step, in, N, integration step, latched at start
- i_flat, in, N*NUM_NEURONS, input currents; neuron k at bits [k*N +: N], latched at start
- dp_v, out, N, operand v to datapath
- dp_w, out, N, operand w to datapath
- dp_i, out, N, operand i to datapath
- dp_step, out, N, latched step
- dp_valid, out, 1, operands valid this cycle
- dp_dv, in, N, dv*step result, valid DP_LAT cycles after dp_valid
- dp_dw, in, N, dw*step result, same timing
- busy, out, 1, sweep in progress
- done, out, 1, one-cycle pulse at sweep end
- spike_valid, out, 1, one-cycle pulse per spiking neuron
- spike_idx, out, IDX_W, index of spiking neuron
- v_mon, out, N, v of neuron 0 (debug monitor)

Behaviour:
- Reset (rst_n low, async):
  - All v = V_RESET (-65.0 = 0xFFBF00); all w = W_INIT (-13.0 = 0xFFF300).
  - busy, done, dp_valid, spike_valid = 0; spike_idx = 0; dp_* operands = 0; FSM = IDLE.
  - Reset mid-sweep aborts the sweep; there is no partial writeback.
- FSM states:
  - IDLE: `start` -> latch step and i_flat, idx = 0, go to ISSUE; busy = 1 from the next cycle.
  - ISSUE: drive dp_v/dp_w/dp_i for idx and dp_valid = 1 for one cycle -> WAIT with cnt = DP_LAT. If DP_LAT = 0, go straight to WB, sampling dp_dv/dp_dw in the same cycle.
  - WAIT: decrement cnt; at cnt = 1, go to WB.
  - WB: sample dp_dv/dp_dw, then update neuron idx:
    - v' = v + dv; w' = w + dw.
    - If v' >= V_PEAK (30.0 = 0x001E00, signed compare): v <= C_RESET (-65.0), w <= w' + D_INC (8.0 = 0x000800), and spike_valid = 1 with spike_idx = idx in the cycle after WB.
    - Otherwise v <= v', w <= w'.
    - If idx == NUM_NEURONS-1 -> DONE, else idx++ and go to ISSUE.
  - DONE: done = 1 for one cycle, busy = 0 -> IDLE.
- Timing: one neuron takes DP_LAT+2 cycles; sweep latency = NUM_NEURONS*(DP_LAT+2)+1 cycles from start to done.
- Only one operation is in flight at a time; there is no operand pipelining.
- dp_v/dp_w/dp_i hold their last values when dp_valid = 0.
- Arithmetic: additions are N-bit two's complement and wrap on overflow (default build). The spike compare uses the wrapped sum.
- `start` while busy is ignored with no error. `start` in the same cycle as DONE is ignored; it is accepted from IDLE on the next cycle.
- v_mon is a registered copy of v[0] and updates in the cycle after its write.

Optional Feature:
- IZH_SAT_EN defined: v+dv and w+dw (including w+D_INC) saturate to [-2^(N-1), 2^(N-1)-1] instead of wrapping; an overflow to max counts as a spike.
- Undefined: plain wrap-around addition as above.

Decomposition:
- Package izh_pkg holds:
  - constants V_RESET, W_INIT, V_PEAK, C_RESET, D_INC (24-bit Q8)
  - FSM state enum (IDLE, ISSUE, WAIT, WB, DONE)
  - fixed-point add function with the IZH_SAT_EN variant
- One natural sub-module: izh_state_rf, a NUM_NEURONS-entry v/w register file with single-write, two-read ports and async-reset init values.

Test Plan:
- Reset then immediate start, i = 0, with a stub datapath returning dv = 0x000100 (1.0) and dw = 0 -> all v = -64.0 (0xFFC000), done exactly NUM_NEURONS*(DP_LAT+2)+1 cycles after start, no spikes.
- Neuron 2 preloaded near peak (stub returns dv = 95.0 once) -> spike_valid with spike_idx = 2; v[2] = 0xFFBF00; w[2] = W_INIT + 8.0 = 0xFFFB00; other neurons unaffected.
- start pulsed again mid-sweep and on the DONE cycle -> ignored, busy profile unchanged; a start in IDLE afterwards is accepted.
- rst_n asserted during WAIT of neuron 1 -> outputs go to reset values the same cycle (async); the next sweep starts from V_RESET for all neurons.
- Overflow: v = 0x7FFF00 with dv = 0x000200 -> wraps negative and produces no spike (default build); with IZH_SAT_EN, v saturates to 0x7FFFFF, spike fires, and v resets to -65.0.
- DP_LAT = 0 and DP_LAT = 4 builds: dp_valid-to-sample spacing matches DP_LAT, and the sweep result matches a reference model over 100 random steps.

Source files
------------

// File: rtl/izh_pkg.sv
// Shared constants, FSM encoding and fixed-point adder for the Izhikevich step scheduler.
// Build option: define IZH_SAT_EN to make the v/w adders saturate instead of wrap.
package izh_pkg;

  // Model constants in whole units; the scheduler scales them by 2**Q.
  localparam int V_RESET_I = -65;
  localparam int W_INIT_I  = -13;
  localparam int V_PEAK_I  = 30;
  localparam int C_RESET_I = -65;
  localparam int D_INC_I   = 8;

  // Reference encodings at the default 24-bit Q8 format.
  localparam logic [23:0] V_RESET = 24'hFFBF00;
  localparam logic [23:0] W_INIT  = 24'hFFF300;
  localparam logic [23:0] V_PEAK  = 24'h001E00;
  localparam logic [23:0] C_RESET = 24'hFFBF00;
  localparam logic [23:0] D_INC   = 24'h000800;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    WB    = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Operands arrive sign-extended to 64 bits; result is valid in its low w bits.
  function automatic logic [63:0] fx_add(input logic [63:0] a, input logic [63:0] b,
                                         input int unsigned w);
    logic signed [63:0] s;
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    s = $signed(a) + $signed(b);
`ifdef IZH_SAT_EN
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    if (s > mx)      s = mx;
    else if (s < mn) s = mn;
`else
    mx = '0;
    mn = '0;
    s  = (s <<< (64 - w)) >>> (64 - w);
`endif
    return s;
  endfunction

endpackage

// File: rtl/izh_state_rf.sv
// Per-neuron v/w register file: one write port, indexed read port plus a fixed tap on neuron 0.
module izh_state_rf
  import izh_pkg::*;
#(
  parameter int          N           = 24,
  parameter int          NUM_NEURONS = 4,
  parameter int          IDX_W       = 2,
  parameter logic [N-1:0] V_INIT_VAL = '0,
  parameter logic [N-1:0] W_INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [N-1:0]     wv,
  input  logic [N-1:0]     ww,
  input  logic [IDX_W-1:0] raddr,
  output logic [N-1:0]     rv,
  output logic [N-1:0]     rw,
  output logic [N-1:0]     v0
);

  logic [N-1:0] v_q [NUM_NEURONS];
  logic [N-1:0] w_q [NUM_NEURONS];
  logic [N-1:0] v_d [NUM_NEURONS];
  logic [N-1:0] w_d [NUM_NEURONS];

  // Next-state: single-entry write
  always_comb begin
    v_d = v_q;
    w_d = w_q;
    if (we) begin
      v_d[waddr] = wv;
      w_d[waddr] = ww;
    end
  end

  // State registers with resting-potential init on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_NEURONS; k++) begin
        v_q[k] <= V_INIT_VAL;
        w_q[k] <= W_INIT_VAL;
      end
    end else begin
      v_q <= v_d;
      w_q <= w_d;
    end
  end

  assign rv = v_q[raddr];
  assign rw = w_q[raddr];
  assign v0 = v_q[0];

endmodule

// File: rtl/izh_step_sched.sv
// Izhikevich step scheduler: time-multiplexes one dv/dw datapath over NUM_NEURONS neurons.
// Build option: IZH_SAT_EN selects saturating v/w integration (see izh_pkg::fx_add).
module izh_step_sched
  import izh_pkg::*;
#(
  parameter int N           = 24,
  parameter int Q           = 8,
  parameter int NUM_NEURONS = 4,
  parameter int DP_LAT      = 2,
  parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [N-1:0]             step,
  input  logic [N*NUM_NEURONS-1:0] i_flat,
  output logic [N-1:0]             dp_v,
  output logic [N-1:0]             dp_w,
  output logic [N-1:0]             dp_i,
  output logic [N-1:0]             dp_step,
  output logic                     dp_valid,
  input  logic [N-1:0]             dp_dv,
  input  logic [N-1:0]             dp_dw,
  output logic                     busy,
  output logic                     done,
  output logic                     spike_valid,
  output logic [IDX_W-1:0]         spike_idx,
  output logic [N-1:0]             v_mon
);

  localparam int CNT_W = (DP_LAT > 1) ? $clog2(DP_LAT + 1) : 1;
  localparam logic [N-1:0] V_RST  = N'(V_RESET_I * (2 ** Q));
  localparam logic [N-1:0] W_RST  = N'(W_INIT_I  * (2 ** Q));
  localparam logic [N-1:0] V_PK   = N'(V_PEAK_I  * (2 ** Q));
  localparam logic [N-1:0] C_RST  = N'(C_RESET_I * (2 ** Q));
  localparam logic [N-1:0] D_STEP = N'(D_INC_I   * (2 ** Q));
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [N-1:0]             step_q, step_d;
  logic [N*NUM_NEURONS-1:0] i_q, i_d;
  logic [N-1:0]             dv_q, dv_d, dw_q, dw_d;
  logic [N-1:0]             op_v_q, op_v_d, op_w_q, op_w_d, op_i_q, op_i_d;
  logic                     spike_valid_q, spike_valid_d;
  logic [IDX_W-1:0]         spike_idx_q, spike_idx_d;
  logic [N-1:0]             v_mon_q, v_mon_d;

  logic [N-1:0] rd_v, rd_w, rf_v0, wr_v, wr_w, cur_i;
  logic [N-1:0] v_sum, w_sum, w_inc;
  logic         wr_en, fire;

  izh_state_rf #(
    .N          (N),
    .NUM_NEURONS(NUM_NEURONS),
    .IDX_W      (IDX_W),
    .V_INIT_VAL (V_RST),
    .W_INIT_VAL (W_RST)
  ) u_rf (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wr_en),
    .waddr(idx_q),
    .wv   (wr_v),
    .ww   (wr_w),
    .raddr(idx_q),
    .rv   (rd_v),
    .rw   (rd_w),
    .v0   (rf_v0)
  );

  assign cur_i = i_q[int'(idx_q)*N +: N];

  // Integration arithmetic for the neuron currently addressed
  always_comb begin
    v_sum = N'(fx_add(64'($signed(rd_v)), 64'($signed(dv_q)), N));
    w_sum = N'(fx_add(64'($signed(rd_w)), 64'($signed(dw_q)), N));
    w_inc = N'(fx_add(64'($signed(w_sum)), 64'($signed(D_STEP)), N));
    fire  = ($signed(v_sum) >= $signed(V_PK));
  end

  // Sweep sequencing: the result is captured on the edge entering WB, i.e. DP_LAT cycles after ISSUE
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    step_d        = step_q;
    i_d           = i_q;
    dv_d          = dv_q;
    dw_d          = dw_q;
    op_v_d        = op_v_q;
    op_w_d        = op_w_q;
    op_i_d        = op_i_q;
    spike_valid_d = 1'b0;
    spike_idx_d   = spike_idx_q;
    v_mon_d       = rf_v0;
    wr_en         = 1'b0;
    wr_v          = v_sum;
    wr_w          = w_sum;
    case (state_q)
      IDLE: begin
        if (start) begin
          step_d  = step;
          i_d     = i_flat;
          idx_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        op_v_d = rd_v;
        op_w_d = rd_w;
        op_i_d = cur_i;
        if (DP_LAT == 0) begin
          dv_d    = dp_dv;
          dw_d    = dp_dw;
          state_d = WB;
        end else begin
          cnt_d   = CNT_W'(DP_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          dv_d    = dp_dv;
          dw_d    = dp_dw;
          state_d = WB;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WB: begin
        wr_en = 1'b1;
        if (fire) begin
          wr_v          = C_RST;
          wr_w          = w_inc;
          spike_valid_d = 1'b1;
          spike_idx_d   = idx_q;
        end
        if (idx_q == LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ISSUE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      step_q        <= '0;
      i_q           <= '0;
      dv_q          <= '0;
      dw_q          <= '0;
      op_v_q        <= '0;
      op_w_q        <= '0;
      op_i_q        <= '0;
      spike_valid_q <= 1'b0;
      spike_idx_q   <= '0;
      v_mon_q       <= V_RST;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      step_q        <= step_d;
      i_q           <= i_d;
      dv_q          <= dv_d;
      dw_q          <= dw_d;
      op_v_q        <= op_v_d;
      op_w_q        <= op_w_d;
      op_i_q        <= op_i_d;
      spike_valid_q <= spike_valid_d;
      spike_idx_q   <= spike_idx_d;
      v_mon_q       <= v_mon_d;
    end
  end

  // Operands are live during ISSUE and held from the last issue otherwise
  assign dp_valid    = (state_q == ISSUE);
  assign dp_v        = dp_valid ? rd_v  : op_v_q;
  assign dp_w        = dp_valid ? rd_w  : op_w_q;
  assign dp_i        = dp_valid ? cur_i : op_i_q;
  assign dp_step     = step_q;
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign done        = (state_q == DONE);
  assign spike_valid = spike_valid_q;
  assign spike_idx   = spike_idx_q;
  assign v_mon       = v_mon_q;

endmodule

// File: tb/tb_izh_step_sched.sv
// Scoreboard bench for izh_step_sched with a fixed-latency stub datapath.
module tb_izh_step_sched;

  localparam int N  = 24;
  localparam int NN = 4;
  localparam int L  = 2;
  localparam int PI = (L == 0) ? 0 : L - 1;
  localparam logic [23:0] JUNK = 24'hA5A5A5;

  typedef struct packed {
    logic [23:0] v;
    logic [23:0] w;
    logic [23:0] i;
    logic [23:0] s;
  } op_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  step;
  logic [N*NN-1:0] i_flat;
  logic [N-1:0]  dp_v, dp_w, dp_i, dp_step, dp_dv, dp_dw, v_mon;
  logic          dp_valid, busy, done, spike_valid;
  logic [1:0]    spike_idx;

  izh_step_sched #(.N(N), .Q(8), .NUM_NEURONS(NN), .DP_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step), .i_flat(i_flat),
    .dp_v(dp_v), .dp_w(dp_w), .dp_i(dp_i), .dp_step(dp_step), .dp_valid(dp_valid),
    .dp_dv(dp_dv), .dp_dw(dp_dw), .busy(busy), .done(done),
    .spike_valid(spike_valid), .spike_idx(spike_idx), .v_mon(v_mon)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  logic [23:0] dv_tab [NN];
  logic [23:0] dw_tab [NN];
  logic [23:0] i_tab  [NN];
  logic [23:0] step_val;
  logic [23:0] mv [NN];
  logic [23:0] mw [NN];

  op_t exp_op [$];
  int  exp_spk [$];
  int  exp_done [$];

  // Stub datapath: per-neuron table value, delayed L cycles, junk when not valid
  int scnt;
  logic [23:0] dv_now, dw_now;
  logic        pv  [PI+1];
  logic [23:0] pdv [PI+1];
  logic [23:0] pdw [PI+1];
  assign dv_now = dv_tab[scnt];
  assign dw_now = dw_tab[scnt];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) scnt <= 0;
    else if (dp_valid) scnt <= (scnt == NN - 1) ? 0 : scnt + 1;
  end
  always @(posedge clk) begin
    pv[0]  <= dp_valid;
    pdv[0] <= dv_now;
    pdw[0] <= dw_now;
    for (int k = 1; k <= PI; k++) begin
      pv[k]  <= pv[k-1];
      pdv[k] <= pdv[k-1];
      pdw[k] <= pdw[k-1];
    end
  end
  assign dp_dv = (L == 0) ? (dp_valid ? dv_now : JUNK) : (pv[PI] ? pdv[PI] : JUNK);
  assign dp_dw = (L == 0) ? (dp_valid ? dw_now : JUNK) : (pv[PI] ? pdw[PI] : JUNK);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] m_add(input logic [23:0] a, input logic [23:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
`ifdef IZH_SAT_EN
    if (s > 64'sd8388607)  s = 64'sd8388607;
    if (s < -64'sd8388608) s = -64'sd8388608;
`endif
    return s[23:0];
  endfunction

  // Monitor: pops expectations whenever the DUT presents operands, spikes or done
  always @(negedge clk) begin
    if (rst_n) begin
      if (dp_valid) begin
        if (exp_op.size() == 0) chk("op_unexpected", 64'd0, 64'd1);
        else begin
          op_t e;
          e = exp_op.pop_front();
          chk("dp_v", 64'(dp_v), 64'(e.v));
          chk("dp_w", 64'(dp_w), 64'(e.w));
          chk("dp_i", 64'(dp_i), 64'(e.i));
          chk("dp_step", 64'(dp_step), 64'(e.s));
        end
      end
      if (spike_valid) begin
        if (exp_spk.size() == 0) chk("spike_unexpected", 64'(spike_idx), 64'hFF);
        else chk("spike_idx", 64'(spike_idx), 64'(exp_spk.pop_front()));
      end
      if (done) begin
        if (exp_done.size() == 0) chk("done_unexpected", 64'd0, 64'd1);
        else chk("done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
      end
    end
  end

  task automatic model_reset();
    for (int k = 0; k < NN; k++) begin
      mv[k] = 24'hFFBF00;
      mw[k] = 24'hFFF300;
    end
  endtask

  task automatic launch(output int s);
    @(negedge clk);
    step = step_val;
    for (int k = 0; k < NN; k++) i_flat[k*N +: N] = i_tab[k];
    start = 1'b1;
    s = cyc;
  endtask

  // One full sweep; optionally pokes start mid-sweep and/or on the DONE cycle
  task automatic sweep(input int mid_poke, input bit done_poke);
    int s;
    bit seen;
    logic [23:0] nv, nw;
    for (int k = 0; k < NN; k++) begin
      exp_op.push_back('{v: mv[k], w: mw[k], i: i_tab[k], s: step_val});
      nv = m_add(mv[k], dv_tab[k]);
      nw = m_add(mw[k], dw_tab[k]);
      if ($signed(nv) >= $signed(24'h001E00)) begin
        mv[k] = 24'hFFBF00;
        mw[k] = m_add(nw, 24'h000800);
        exp_spk.push_back(k);
      end else begin
        mv[k] = nv;
        mw[k] = nw;
      end
    end
    launch(s);
    exp_done.push_back(s + NN * (L + 2) + 1);
    seen = 1'b0;
    for (int r = 1; r <= 200 && !seen; r++) begin
      @(negedge clk);
      start = (r == mid_poke);
      if (done) begin
        seen  = 1'b1;
        start = done_poke;
      end
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
    start = 1'b0;
    if (done_poke) begin
      for (int r = 0; r < 3; r++) begin
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_dp_valid", 64'(dp_valid), 64'd0);
      end
    end
    @(negedge clk);
    chk("v_mon", 64'(v_mon), 64'(mv[0]));
  endtask

  task automatic set_tabs(input logic [23:0] d0, d1, d2, d3);
    dv_tab[0] = d0; dv_tab[1] = d1; dv_tab[2] = d2; dv_tab[3] = d3;
    for (int k = 0; k < NN; k++) dw_tab[k] = 24'h0;
  endtask

  initial begin
    int s;
    rst_n = 1'b0; start = 1'b0; step = '0; i_flat = '0;
    step_val = 24'h000040;
    for (int k = 0; k < NN; k++) i_tab[k] = 24'h0;
    set_tabs(24'h0, 24'h0, 24'h0, 24'h0);
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dp_valid", 64'(dp_valid), 64'd0);
    chk("rst_spike_valid", 64'(spike_valid), 64'd0);
    chk("rst_spike_idx", 64'(spike_idx), 64'd0);
    chk("rst_dp_v", 64'(dp_v), 64'd0);
    chk("rst_dp_w", 64'(dp_w), 64'd0);
    chk("rst_dp_i", 64'(dp_i), 64'd0);
    chk("rst_dp_step", 64'(dp_step), 64'd0);
    chk("rst_v_mon", 64'(v_mon), 64'hFFBF00);
    rst_n = 1'b1;

    // dv = 1.0 everywhere: all v go to -64.0
    set_tabs(24'h000100, 24'h000100, 24'h000100, 24'h000100);
    sweep(0, 1'b0);
    chk("v0_after_plus1", 64'(v_mon), 64'hFFC000);

    // Neuron 2 pushed past peak; distinct currents check i_flat slicing
    i_tab[0] = 24'h000A00; i_tab[1] = 24'h000B00; i_tab[2] = 24'h000C00; i_tab[3] = 24'h000D00;
    step_val = 24'h000080;
    set_tabs(24'h0, 24'h0, 24'h005F00, 24'h0);
    sweep(0, 1'b0);

    // Neuron 1 to 29.0 (no spike), then a huge dv that overflows
    set_tabs(24'h0, 24'h001D00 - mv[1], 24'h0, 24'h0);
    sweep(0, 1'b0);
    set_tabs(24'h0, 24'h7FFF00, 24'h0, 24'h0);
    sweep(0, 1'b0);

    // Observation sweep with start poked mid-sweep and on the DONE cycle
    set_tabs(24'h0, 24'h0, 24'h0, 24'h0);
    sweep(5, 1'b1);

    // Reset during WAIT of neuron 1 aborts the sweep
    exp_op.push_back('{v: mv[0], w: mw[0], i: i_tab[0], s: step_val});
    exp_op.push_back('{v: mv[1], w: mw[1], i: i_tab[1], s: step_val});
    launch(s);
    exp_done.push_back(s + NN * (L + 2) + 1);
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    chk("pre_rst_dp_valid", 64'(dp_valid), 64'd0);
    chk("pre_rst_ops_consumed", 64'(exp_op.size()), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_dp_v", 64'(dp_v), 64'd0);
    chk("arst_spike_valid", 64'(spike_valid), 64'd0);
    exp_done.delete();
    exp_spk.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sweep(0, 1'b0);

    // 25 random sweeps = 100 neuron steps
    for (int t = 0; t < 25; t++) begin
      step_val = 24'($urandom);
      for (int k = 0; k < NN; k++) begin
        dv_tab[k] = 24'(int'($urandom_range(0, 24'h6000)) - 24'h3000);
        dw_tab[k] = 24'(int'($urandom_range(0, 24'h0800)) - 24'h0400);
        i_tab[k]  = 24'($urandom);
      end
      sweep(0, 1'b0);
    end
    set_tabs(24'h0, 24'h0, 24'h0, 24'h0);
    sweep(0, 1'b0);

    repeat (4) @(negedge clk);
    chk("ops_drained", 64'(exp_op.size()), 64'd0);
    chk("spikes_drained", 64'(exp_spk.size()), 64'd0);
    chk("done_drained", 64'(exp_done.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
